// File: rtl/freq_gen_pkg.sv
// Shared types and constants for the programmable square-wave stimulus generator.
package freq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } gen_state_e;

    localparam int DEF_ACC_W = 24;
    localparam int DEF_CNT_W = 16;

    localparam logic [63:0] HALF_SCALE = 64'd1 << (DEF_ACC_W - 1);

    function automatic logic [63:0] half_scale(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/freq_test_gen.sv
// NCO-based square-wave generator with optional exact pulse bursts and graceful stop,
// intended to drive the frequency counter's measured-signal input for self-test.
module freq_test_gen
    import freq_gen_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [ACC_W-1:0] cfg_inc,
    input  logic [CNT_W-1:0] cfg_pulses,
    input  logic             start,
    input  logic             stop,
    output logic             sig_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] edge_count
);

    localparam logic [ACC_W-1:0] HALF_INC = (ACC_W == DEF_ACC_W) ? ACC_W'(HALF_SCALE)
                                                                  : ACC_W'(half_scale(ACC_W));
    localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    gen_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d, inc_q, inc_d, run_inc_q, run_inc_d;
    logic [CNT_W-1:0] pulses_q, pulses_d, run_pulses_q, run_pulses_d;
    logic [CNT_W-1:0] edge_count_q, edge_count_d;
    logic             sig_q, sig_d, busy_q, busy_d, done_q, done_d, ready_q, ready_d;
    logic [ACC_W-1:0] acc_next_s;
    logic             next_msb_s, burst_end_s;

    // Next-state logic; a run works from its own copy of the config so offers taken mid-flight wait for the next run.
    always_comb begin
        acc_next_s   = acc_q + run_inc_q;
        next_msb_s   = acc_next_s[ACC_W-1];
        burst_end_s  = (run_pulses_q != CNT_ZERO) && (edge_count_q == run_pulses_q) && !next_msb_s;
        state_d      = state_q;
        acc_d        = acc_q;
        inc_d        = inc_q;
        pulses_d     = pulses_q;
        run_inc_d    = run_inc_q;
        run_pulses_d = run_pulses_q;
        edge_count_d = edge_count_q;
        sig_d        = sig_q;
        done_d       = 1'b0;

        if (cfg_valid && ready_q) begin
            inc_d    = (cfg_inc > HALF_INC) ? HALF_INC : cfg_inc;
            pulses_d = cfg_pulses;
        end else begin
            inc_d    = inc_q;
            pulses_d = pulses_q;
        end

        case (state_q)
            IDLE: begin
                sig_d = 1'b0;
                if (start && (inc_q != ACC_ZERO)) begin
                    state_d      = RUN;
                    acc_d        = ACC_ZERO;
                    edge_count_d = CNT_ZERO;
                    run_inc_d    = inc_q;
                    run_pulses_d = pulses_q;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = acc_next_s;
                // A stop that lands on the falling cycle ends here rather than entering DRAIN.
                if (burst_end_s || (stop && (!sig_q || !next_msb_s))) begin
                    state_d = IDLE;
                    sig_d   = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    sig_d   = next_msb_s;
                    state_d = stop ? DRAIN : RUN;
                    if (next_msb_s && !sig_q && (edge_count_q != CNT_MAX)) begin
                        edge_count_d = edge_count_q + CNT_ONE;
                    end else begin
                        edge_count_d = edge_count_q;
                    end
                end
            end
            DRAIN: begin
                acc_d = acc_next_s;
                if (!next_msb_s) begin
                    state_d = IDLE;
                    sig_d   = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = DRAIN;
                    sig_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                sig_d   = 1'b0;
            end
        endcase

        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_q        <= ACC_ZERO;
            inc_q        <= ACC_ZERO;
            pulses_q     <= CNT_ZERO;
            run_inc_q    <= ACC_ZERO;
            run_pulses_q <= CNT_ZERO;
            edge_count_q <= CNT_ZERO;
            sig_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            inc_q        <= inc_d;
            pulses_q     <= pulses_d;
            run_inc_q    <= run_inc_d;
            run_pulses_q <= run_pulses_d;
            edge_count_q <= edge_count_d;
            sig_q        <= sig_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ready_q      <= ready_d;
        end
    end

    assign cfg_ready  = ready_q;
    assign sig_out    = sig_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign edge_count = edge_count_q;

endmodule

// File: tb/tb_freq_test_gen.sv
// Self-checking bench for freq_test_gen: directed and random runs against a waveform-level model.
module tb_freq_test_gen;

    localparam int ACC_W = 8;
    localparam int CNT_W = 4;
    localparam int NMAX  = 320;
    localparam int CMAX  = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [ACC_W-1:0] cfg_inc;
    logic [CNT_W-1:0] cfg_pulses;
    logic             start;
    logic             stop;
    logic             sig_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] edge_count;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    int exp_sig  [0:NMAX];
    int exp_busy [0:NMAX];
    int exp_done [0:NMAX];
    int exp_cnt  [0:NMAX];

    freq_test_gen #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_inc(cfg_inc), .cfg_pulses(cfg_pulses),
        .start(start), .stop(stop),
        .sig_out(sig_out), .busy(busy), .done(done), .edge_count(edge_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp, input int cyc);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cyc=%0d: observed %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Ideal wave of cycle k after start is the MSB of (k-1)*inc; the run is that wave cut at its end cycle.
    task automatic build_model(input int inc_raw, input int pulses, input int stop_at, input int n);
        int w [0:NMAX];
        int inc, rises;
        bit ended, stopped, stop_low;
        inc = (inc_raw > 128) ? 128 : inc_raw;
        w[0] = 0;
        for (int k = 1; k <= n; k++) w[k] = ((((k - 1) * inc) % 256) >= 128) ? 1 : 0;
        rises = 0; ended = 0; stopped = 0; stop_low = 0;
        for (int k = 1; k <= n; k++) begin
            exp_done[k] = 0;
            if (!ended) begin
                if ((pulses != 0 && rises == pulses && w[k] == 0) ||
                    (stopped && (stop_low || w[k] == 0))) begin
                    ended = 1;
                    exp_done[k] = 1;
                end else if (w[k] == 1 && w[k-1] == 0 && rises < CMAX) begin
                    rises++;
                end
            end
            exp_sig[k]  = ended ? 0 : w[k];
            exp_busy[k] = ended ? 0 : 1;
            exp_cnt[k]  = rises;
            if (k == stop_at && !ended) begin
                stopped  = 1;
                stop_low = (w[k] == 0);
            end
        end
    endtask

    task automatic run_case(input int inc_v, input int pul_v, input bit do_cfg, input int stop_at,
                            input int n, input bit hold, input int h_inc, input int h_pul);
        if (do_cfg) begin
            chk("ready_before_cfg", 32'(cfg_ready), 32'd1, 0);
            cfg_valid  = 1'b1;
            cfg_inc    = ACC_W'(inc_v);
            cfg_pulses = CNT_W'(pul_v);
            step();
            cfg_valid  = 1'b0;
        end
        build_model(inc_v, pul_v, stop_at, n);
        if (hold) begin
            cfg_valid  = 1'b1;
            cfg_inc    = ACC_W'(h_inc);
            cfg_pulses = CNT_W'(h_pul);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= n; k++) begin
            chk("sig_out",    32'(sig_out),    32'(exp_sig[k]),  k);
            chk("busy",       32'(busy),       32'(exp_busy[k]), k);
            chk("done",       32'(done),       32'(exp_done[k]), k);
            chk("edge_count", 32'(edge_count), 32'(exp_cnt[k]),  k);
            chk("cfg_ready",  32'(cfg_ready),  32'(1 - exp_busy[k]), k);
            stop = (k == stop_at);
            step();
        end
        stop      = 1'b0;
        cfg_valid = 1'b0;
    endtask

    initial begin
        int r_inc, r_pul, r_stop;
        rst = 1'b1; cfg_valid = 1'b0; cfg_inc = '0; cfg_pulses = '0; start = 1'b0; stop = 1'b0;
        step();
        step();
        chk("rst_sig",   32'(sig_out),    32'd0, 0);
        chk("rst_busy",  32'(busy),       32'd0, 0);
        chk("rst_done",  32'(done),       32'd0, 0);
        chk("rst_ready", 32'(cfg_ready),  32'd1, 0);
        chk("rst_cnt",   32'(edge_count), 32'd0, 0);
        rst = 1'b0;
        step();

        run_case(64, 3, 1'b1, -1, 16, 1'b0, 0, 0);
        run_case(64, 0, 1'b1, 39, 45, 1'b0, 0, 0);
        run_case(255, 2, 1'b1, -1, 8, 1'b0, 0, 0);
        run_case(128, 0, 1'b1, 38, 42, 1'b0, 0, 0);
        run_case(64, 0, 1'b1, 5, 8, 1'b0, 0, 0);
        run_case(64, 1, 1'b1, 4, 8, 1'b0, 0, 0);
        run_case(64, 2, 1'b1, -1, 14, 1'b1, 255, 1);
        run_case(255, 1, 1'b0, -1, 6, 1'b0, 0, 0);

        for (int i = 0; i < 6; i++) begin
            r_inc  = $urandom_range(255, 16);
            r_pul  = $urandom_range(15, 0);
            r_stop = ($urandom_range(1, 0) == 1 || r_pul == 0) ? int'($urandom_range(280, 5)) : -1;
            run_case(r_inc, r_pul, 1'b1, r_stop, 300, 1'b0, 0, 0);
        end

        cfg_valid = 1'b1; cfg_inc = 8'h40; cfg_pulses = 4'd0;
        step();
        cfg_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k < 11; k++) step();
        chk("pre_rst_sig", 32'(sig_out),    32'd1, 11);
        chk("pre_rst_cnt", 32'(edge_count), 32'd3, 11);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_sig",   32'(sig_out),    32'd0, 0);
        chk("async_rst_busy",  32'(busy),       32'd0, 0);
        chk("async_rst_cnt",   32'(edge_count), 32'd0, 0);
        chk("async_rst_done",  32'(done),       32'd0, 0);
        chk("async_rst_ready", 32'(cfg_ready),  32'd1, 0);
        step();
        rst = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk("post_rst_busy", 32'(busy),    32'd0, k);
            chk("post_rst_done", 32'(done),    32'd0, k);
            chk("post_rst_sig",  32'(sig_out), 32'd0, k);
            step();
        end

        cfg_valid = 1'b1; cfg_inc = 8'h00; cfg_pulses = 4'd2;
        step();
        cfg_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            chk("zero_inc_busy", 32'(busy), 32'd0, k);
            chk("zero_inc_done", 32'(done), 32'd0, k);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/freq_test_gen.md
Name: freq_test_gen

Overview:
Programmable square-wave stimulus generator. It is the transmit-side counterpart of the frequency counter: it produces a signal of known frequency and, optionally, an exact number of pulses, for on-chip self-test and loopback into the counter input. A phase accumulator (NCO) sets the frequency. A valid/ready config port and start/stop controls set the run mode. Its output feeds the counter's measured-signal input, so a measured value can be checked against a programmed one.

Parameters:
ACC_W, 24, phase accumulator width; f_out = f_clk * inc / 2^ACC_W
CNT_W, 16, width of pulse-count config and edge counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cfg_valid  in  1  config offer
cfg_ready  out  1  config accept; high only in IDLE
cfg_inc  in  ACC_W  phase increment
cfg_pulses  in  CNT_W  burst length; 0 = continuous
start  in  1  begin generation (level-sampled each clk)
stop  in  1  request graceful stop
sig_out  out  1  generated square wave (registered)
busy  out  1  high in RUN or DRAIN
done  out  1  one-cycle pulse on return to IDLE from RUN/DRAIN
edge_count  out  CNT_W  rising edges emitted since last start; held after done

Behaviour:
- Reset, asynchronous: state=IDLE; acc, inc_r, pulses_r, edge_count=0; sig_out=0, busy=0, done=0, cfg_ready=1.
- Config:
  - Transfer occurs when cfg_valid && cfg_ready; inc_r and pulses_r load on that edge.
  - cfg_inc above 2^(ACC_W-1) is clamped to 2^(ACC_W-1), i.e. f_clk/2.
  - cfg_ready=0 outside IDLE; offers wait, with no loss and no partial load.
- States are IDLE, RUN and DRAIN.
- IDLE:
  - start=1 with inc_r!=0: next cycle state=RUN, acc=0, sig_out=0, edge_count=0, busy=1.
  - start with inc_r==0 is ignored.
  - If cfg transfer and start occur in the same cycle, start uses the OLD inc_r/pulses_r.
- RUN:
  - Each cycle acc <= acc + inc_r, modulo 2^ACC_W (wrap is intended).
  - sig_out <= MSB of the new acc.
  - A 0->1 transition of sig_out increments edge_count, which saturates at all-ones.
- Burst end: pulses_r!=0, edge_count==pulses_r and the next MSB is 0.
  - Go to IDLE with sig_out=0 and busy=0.
  - done=1 for exactly that one cycle.
  - The last pulse is never truncated.
- stop in RUN:
  - If sig_out=0, go to IDLE next cycle with done=1.
  - Otherwise go to DRAIN.
- DRAIN:
  - acc keeps advancing; no new rising edge can occur before the fall.
  - On the next fall go to IDLE, done=1.
- Ignored inputs: start in RUN/DRAIN; stop in IDLE.
- Stop and burst end in the same cycle: one done pulse only.
- Continuous mode (pulses_r=0) runs until stop. edge_count saturates rather than wrapping.
- Reset mid-run aborts immediately: sig_out=0, done not asserted.
- Latency: first rising edge of sig_out is ceil(2^(ACC_W-1)/inc_r)+1 cycles after start is sampled.

Decomposition:
- Package freq_gen_pkg: state enum (IDLE, RUN, DRAIN), default ACC_W/CNT_W constants, clamp constant HALF_SCALE = 2^(ACC_W-1).
- Single module, no sub-module; the accumulator is one adder plus register and is kept inline.

Test Plan:
- ACC_W=8, inc=0x40, pulses=3, start at cycle 0 -> sig_out pattern 0,0,1,1 repeating from cycle 1; edge_count=3; done one cycle at cycle 13 with sig_out=0 and busy=0.
- ACC_W=8, inc=0x40, pulses=0, run 40 cycles, stop while sig_out=1 -> enters DRAIN; done on the falling cycle; edge_count=10 with no partial pulse.
- cfg_inc=0xFF with ACC_W=8 -> clamped to 0x80; sig_out toggles every cycle; pulses=2 gives done 5 cycles after start.
- cfg_valid held during RUN -> cfg_ready=0 until done; the new config loads on the first IDLE cycle and the next run uses it.
- Assert rst mid-RUN -> sig_out, busy and edge_count go to 0 asynchronously; no done pulse; inc_r=0 so a subsequent start is ignored.
- inc_r=0 with start pulsed -> state stays IDLE, busy=0, done=0.
